// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 capture path: FSM states,
// RGB565 field layout and default frame geometry.
package cam_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    VBLANK  = 2'd1,
    ARMED   = 2'd2,
    CAPTURE = 2'd3
  } cam_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int H_PIX_DEF    = 320;
  localparam int V_LINES_DEF  = 240;
  localparam int FRAME_PIXELS = H_PIX_DEF * V_LINES_DEF;

  // The camera sends the high byte first, so the pair maps straight onto R:G:B.
  function automatic rgb565_t rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/cam_capture_edge_det.sv
// One-stage input register with rising/falling edge pulses derived from
// the registered value, so every decision sees a clean pclk-aligned signal.
module cam_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic i_sig,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_q_d;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= i_sig;
      r_q_d <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_q_d;
  assign o_fall = ~r_q & r_q_d;

endmodule

// File: rtl/cam_capture.sv
// OV7670 byte-pair to RGB565 packer writing a row-major frame buffer.
// Optional per-line/per-frame length checking when CAM_CAPTURE_LINECHK_EN is defined.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int ADDR_W  = 17
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              frame_we,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [15:0]       frame_wdata,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
`ifdef CAM_CAPTURE_LINECHK_EN
  ,
  output logic              line_err,
  output logic [9:0]        line_len
`endif
);

  localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(H_PIX * V_LINES);

  logic            w_vs, w_vs_rise, w_vs_fall;
  logic            w_hr, w_hr_rise, w_hr_fall;
  logic [7:0]      r_data;
  logic [7:0]      r_hi;
  logic            r_phase;
  logic [ADDR_W:0] r_cnt;
  cam_state_e      r_state, w_state_nxt;
  logic            w_byte, w_clr, w_sat, w_done_ok;

  cam_edge_det u_vsync (
    .pclk(pclk), .rst(rst), .i_sig(cam_vsync),
    .o_q(w_vs), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
  );

  cam_edge_det u_href (
    .pclk(pclk), .rst(rst), .i_sig(cam_href),
    .o_q(w_hr), .o_rise(w_hr_rise), .o_fall(w_hr_fall)
  );

  always_ff @(posedge pclk) begin
    r_data <= cam_data;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= SYNC;
    else     r_state <= w_state_nxt;
  end

  // vsync high overrides everything; VBLANK only leaves once vsync has dropped.
  always_comb begin
    w_state_nxt = r_state;
    if (w_vs) begin
      w_state_nxt = VBLANK;
    end else begin
      case (r_state)
        SYNC:    w_state_nxt = SYNC;
        VBLANK:  w_state_nxt = ARMED;
        ARMED:   if (w_hr_rise) w_state_nxt = CAPTURE;
        CAPTURE: if (w_hr_fall) w_state_nxt = ARMED;
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_comb begin
    w_byte = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      VBLANK:  w_clr  = w_vs_fall;
      ARMED:   w_byte = w_hr_rise & ~w_vs;
      CAPTURE: w_byte = w_hr & ~w_vs;
      default: ;
    endcase
  end

  assign w_sat = (r_cnt == FRAME_PIX);

  always_ff @(posedge pclk) begin
    if (w_byte && !r_phase) r_hi <= r_data;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_phase     <= 1'b0;
      r_cnt       <= '0;
      frame_we    <= 1'b0;
      frame_addr  <= '0;
      frame_wdata <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_we   <= 1'b0;
      frame_done <= 1'b0;
      if (w_vs || w_hr_fall) r_phase <= 1'b0;
      else if (w_byte)       r_phase <= ~r_phase;
      if (w_clr) begin
        r_cnt      <= '0;
        frame_addr <= '0;
      end else if (w_byte && r_phase && !w_sat) begin
        frame_we    <= 1'b1;
        frame_addr  <= r_cnt[ADDR_W-1:0];
        frame_wdata <= rgb565_pack(r_hi, r_data);
        r_cnt       <= r_cnt + 1'b1;
      end
      if (w_vs_rise && w_done_ok) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef CAM_CAPTURE_LINECHK_EN
  logic [9:0] r_line_pix;
  logic [9:0] r_lines;
  logic       r_bad;

  // Pixels formed on the line are counted even after saturation, so line_len stays honest.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_line_pix <= '0;
      r_lines    <= '0;
      r_bad      <= 1'b0;
      line_err   <= 1'b0;
      line_len   <= '0;
    end else begin
      if (w_vs || w_hr_fall)     r_line_pix <= '0;
      else if (w_byte && r_phase) r_line_pix <= r_line_pix + 10'd1;
      if (w_clr) begin
        r_lines <= '0;
        r_bad   <= 1'b0;
      end else if (r_state == CAPTURE && w_hr_fall) begin
        r_lines  <= r_lines + 10'd1;
        line_len <= r_line_pix;
        if (r_line_pix != 10'(H_PIX)) begin
          line_err <= 1'b1;
          r_bad    <= 1'b1;
        end
      end
      if (w_vs_rise && r_state != SYNC && r_lines != 10'(V_LINES)) line_err <= 1'b1;
    end
  end

  assign w_done_ok = w_sat & ~r_bad;
`else
  assign w_done_ok = w_sat;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture on a reduced 8x6 frame: table-driven frame scenarios,
// hand-written latency/reset sequences and random frames against a byte-level model.
module tb_cam_capture;

  localparam int H     = 8;
  localparam int V     = 6;
  localparam int FRAME = H * V;
`ifdef CAM_CAPTURE_LINECHK_EN
  localparam bit LINECHK = 1'b1;
`else
  localparam bit LINECHK = 1'b0;
`endif

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    string name;
    int    lines;
    int    bpl;
    int    odd_line;
    int    short_line;
    int    abort_line;
    int    abort_bytes;
    int    exp_pix;
    int    exp_done;
  } fvec_t;

  logic        pclk;
  logic        rst;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_we;
  logic [16:0] frame_addr;
  logic [15:0] frame_wdata;
  logic        frame_done;
  logic [7:0]  frame_cnt;
`ifdef CAM_CAPTURE_LINECHK_EN
  logic        line_err;
  logic [9:0]  line_len;
`endif

  cam_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(17)) dut (
    .pclk(pclk), .rst(rst),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_we(frame_we), .frame_addr(frame_addr), .frame_wdata(frame_wdata),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
`ifdef CAM_CAPTURE_LINECHK_EN
    , .line_err(line_err), .line_len(line_len)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Monitor: every write and every done cycle, sampled away from the active edge.
  wr_t act_q[$];
  int  done_seen = 0;
  always @(negedge pclk) begin
    if (frame_we === 1'b1) act_q.push_back('{addr: frame_addr, data: frame_wdata});
    if (frame_done === 1'b1) done_seen++;
  end

  // Reference model state.
  wr_t exp_q[$];
  bit  m_armed = 0;
  int  m_pix = 0;
  bit  m_bad = 0;
  bit  m_done_last = 0;
  int  exp_cnt = 0;
  int  act_base = 0;
  int  done_base = 0;

  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
    end
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge pclk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  // Sends one line (or aborts it with vsync after abort_at bytes) and models its pixels.
  task automatic send_line(input int nbytes, input int abort_at);
    logic [7:0] lb[$];
    logic [7:0] b;
    int n;
    n = (abort_at >= 0) ? abort_at : nbytes;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      lb.push_back(b);
      drive(1'b0, 1'b1, b);
    end
    if (m_armed) begin
      for (int k = 0; k + 1 < lb.size(); k += 2) begin
        if (m_pix < FRAME) exp_q.push_back('{addr: 17'(m_pix), data: {lb[k], lb[k+1]}});
        m_pix++;
      end
      if (abort_at < 0 && (lb.size() / 2) != H) m_bad = 1;
    end
    if (abort_at >= 0) drive(1'b1, 1'b1, 8'h00);
    else repeat ($urandom_range(2, 4)) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync_pulse();
    m_done_last = m_armed && (m_pix >= FRAME) && !(LINECHK && m_bad);
    if (m_done_last) exp_cnt = (exp_cnt + 1) % 256;
    m_pix   = 0;
    m_bad   = 0;
    m_armed = 1;
    repeat (6) drive(1'b1, 1'b0, 8'h00);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_frame(input string tag, input int exp_pix, input int exp_done);
    int n;
    int idx;
    int lim;
    n = act_q.size() - act_base;
    check({tag, " write count"}, 64'(n), 64'(exp_pix));
    lim = (n < exp_q.size()) ? n : exp_q.size();
    if (lim > 0) begin
      idx = lim - 1;
      for (int i = lim - 1; i >= 0; i--) if (act_q[act_base + i] !== exp_q[i]) idx = i;
      check($sformatf("%s pixel[%0d] {addr,data}", tag, idx),
            64'(act_q[act_base + idx]), 64'(exp_q[idx]));
    end
    check({tag, " done pulses"}, 64'(done_seen - done_base), 64'(exp_done));
    check({tag, " frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
    act_base  = act_q.size();
    done_base = done_seen;
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got no finish, expected finish before 1000000");
    $fatal(1, "timeout");
  end

  fvec_t tv[7];

  initial begin
    bit seen;
    int nl;
    int r;

    tv[0] = '{"full",        6, 16, -1, -1, -1,  0, 48, 1};
    tv[1] = '{"odd line",    6, 16,  2, -1, -1,  0, 48, 1};
    tv[2] = '{"short frame", 5, 16, -1, -1, -1,  0, 40, 0};
    tv[3] = '{"oversize",    8, 16, -1, -1, -1,  0, 48, 1};
    tv[4] = '{"abort",       6, 16, -1, -1,  3, 10, 29, 0};
    tv[5] = '{"after abort", 6, 16, -1, -1, -1,  0, 48, 1};
    tv[6] = '{"short line",  6, 16, -1,  1, -1,  0, 45, 0};

    rst = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    repeat (3) @(negedge pclk);
    check("reset frame_we",    64'(frame_we),    64'(0));
    check("reset frame_addr",  64'(frame_addr),  64'(0));
    check("reset frame_wdata", 64'(frame_wdata), 64'(0));
    check("reset frame_done",  64'(frame_done),  64'(0));
    check("reset frame_cnt",   64'(frame_cnt),   64'(0));
    rst = 1'b0;

    // Lines arriving before any vsync cycle must not be captured.
    send_line(16, -1);
    send_line(16, -1);
    vsync_pulse();
    check_frame("no-arm", 0, 0);

    // Two-pclk latency from second byte to the write strobe, single-cycle strobe.
    drive(1'b0, 1'b1, 8'hAB);
    drive(1'b0, 1'b1, 8'hCD);
    drive(1'b0, 1'b0, 8'h00);
    check("latency we after 1 edge", 64'(frame_we), 64'(0));
    drive(1'b0, 1'b0, 8'h00);
    check("latency we after 2 edges", 64'(frame_we), 64'(1));
    check("latency wdata", 64'(frame_wdata), 64'(16'hABCD));
    check("latency addr", 64'(frame_addr), 64'(0));
    drive(1'b0, 1'b0, 8'h00);
    check("latency we after 3 edges", 64'(frame_we), 64'(0));
    exp_q.push_back('{addr: 17'd0, data: 16'hABCD});
    m_pix = 1;
    m_bad = 1;
    vsync_pulse();
    check_frame("latency frame", 1, 0);

    for (int i = 0; i < 7; i++) begin
      for (int l = 0; l < tv[i].lines; l++) begin
        if (l == tv[i].abort_line) begin
          send_line(tv[i].bpl, tv[i].abort_bytes);
          break;
        end
        nl = (l == tv[i].odd_line) ? tv[i].bpl + 1 :
             (l == tv[i].short_line) ? 10 : tv[i].bpl;
        send_line(nl, -1);
      end
      if (tv[i].exp_pix == FRAME)
        check({tv[i].name, " saturated addr"}, 64'(frame_addr), 64'(FRAME - 1));
      vsync_pulse();
      check_frame(tv[i].name, tv[i].exp_pix, tv[i].exp_done);
    end

    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(4, 8);
      for (int l = 0; l < nl; l++) begin
        r = $urandom_range(0, 5);
        if (r == 0)      send_line($urandom_range(2, 14), -1);
        else if (r == 1) send_line(2 * H + 1, -1);
        else             send_line(2 * H, -1);
      end
      vsync_pulse();
      check_frame($sformatf("random frame %0d", f), exp_q.size(), int'(m_done_last));
    end

`ifdef CAM_CAPTURE_LINECHK_EN
    check("line_err sticky", 64'(line_err), 64'(1));
`endif

    // Asynchronous reset in the middle of a captured line.
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive(1'b0, 1'b1, 8'($urandom));
      seen = frame_we;
    end
    check("pre-reset frame_we", 64'(frame_we), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("async rst frame_we",    64'(frame_we),    64'(0));
    check("async rst frame_addr",  64'(frame_addr),  64'(0));
    check("async rst frame_wdata", 64'(frame_wdata), 64'(0));
    check("async rst frame_cnt",   64'(frame_cnt),   64'(0));
    act_base  = act_q.size();
    done_base = done_seen;
    exp_q.delete();
    m_armed = 0;
    m_pix   = 0;
    m_bad   = 0;
    exp_cnt = 0;
    drive(1'b0, 1'b1, 8'h55);
    drive(1'b0, 1'b1, 8'h66);
    rst = 1'b0;
    send_line(12, -1);
    send_line(16, -1);
    vsync_pulse();
    check_frame("post-reset", 0, 0);

    for (int l = 0; l < V; l++) send_line(2 * H, -1);
    vsync_pulse();
    check_frame("resume", FRAME, 1);
`ifdef CAM_CAPTURE_LINECHK_EN
    check("line_len", 64'(line_len), 64'(H));
    check("line_err after clean frame", 64'(line_err), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
